// File: rtl/axis_pattern_gen.sv
// AXI4-Stream test-pattern source: software-triggered bursts of packets with
// selectable incrementing / walking-one / PRBS / inverted patterns and an idle gap.
module axis_pattern_gen #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [1:0]          mode_i,
  input  logic [LEN_W-1:0]    pkt_len_i,
  input  logic [LEN_W-1:0]    pkt_num_i,
  input  logic                S_AXIS_tready,
  output logic                S_AXIS_tvalid,
  output logic [DATA_W-1:0]   S_AXIS_tdata,
  output logic [DATA_W/8-1:0] S_AXIS_tkeep,
  output logic                S_AXIS_tlast,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [LEN_W-1:0]    pkts_sent_o
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int LANES = DATA_W / 32;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic                r_start_d, r_abort, r_tvalid, r_tlast, r_busy, r_done, r_err;
  logic [1:0]          r_mode;
  logic [LEN_W-1:0]    r_len, r_num, r_word_cnt, r_pkts_sent;
  logic [DATA_W-1:0]   r_seq, r_tdata;
  logic [31:0]         r_prbs;
  logic [GAP_W-1:0]    r_gap_cnt;

  logic                w_start, w_fields_ok, w_accept, w_hs, w_last_hs, w_abort, w_run_end, w_gap_end;
  logic [DATA_W-1:0]   w_seq_next;
  logic [31:0]         w_prbs_next;
  logic [LEN_W-1:0]    w_cnt_next;

  function automatic logic [31:0] f_lfsr(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] f_pattern(input logic [1:0] mode,
                                                  input logic [DATA_W-1:0] seq,
                                                  input logic [31:0] prbs);
    logic [DATA_W-1:0] v;
    case (mode)
      2'd0:    v = seq;
      2'd1:    v = {{(DATA_W-1){1'b0}}, 1'b1} << seq[SH_W-1:0];
      2'd2:    v = {LANES{prbs}};
      default: v = ~seq;
    endcase
    return v;
  endfunction

  assign w_start     = start_i & ~r_start_d & (r_state == S_IDLE);
  assign w_fields_ok = (|pkt_len_i) & (|pkt_num_i);
  assign w_accept    = w_start & w_fields_ok;
  assign w_hs        = r_tvalid & S_AXIS_tready;
  assign w_last_hs   = w_hs & r_tlast;
  // The current cycle's abort request counts, so a pulse on the final handshake still ends the run.
  assign w_abort     = r_abort | abort_i;
  assign w_run_end   = ((r_pkts_sent + LEN_W'(1)) == r_num) | w_abort;
  assign w_gap_end   = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign w_seq_next  = r_seq + DATA_W'(1);
  assign w_prbs_next = f_lfsr(r_prbs);
  assign w_cnt_next  = w_last_hs ? '0 : r_word_cnt + LEN_W'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_SEND;
      S_SEND: begin
        if (w_last_hs) begin
          if (w_run_end)           w_state_next = S_DONE;
          else if (GAP_CYCLES > 0) w_state_next = S_GAP;
          else                     w_state_next = S_SEND;
        end
      end
      S_GAP: begin
        if (w_abort)        w_state_next = S_DONE;
        else if (w_gap_end) w_state_next = S_SEND;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_abort     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mode      <= '0;
      r_len       <= '0;
      r_num       <= '0;
      r_word_cnt  <= '0;
      r_pkts_sent <= '0;
      r_seq       <= '0;
      r_prbs      <= '1;
      r_gap_cnt   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_start_d <= start_i;
      r_tvalid  <= (w_state_next == S_SEND);
      r_busy    <= (w_state_next != S_IDLE);
      r_done    <= (w_state_next == S_DONE);
      r_err     <= w_start & ~w_fields_ok;
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;

      if (w_accept) begin
        r_mode      <= mode_i;
        r_len       <= pkt_len_i;
        r_num       <= pkt_num_i;
        r_seq       <= '0;
        r_prbs      <= '1;
        r_word_cnt  <= '0;
        r_pkts_sent <= '0;
        r_abort     <= 1'b0;
        r_tdata     <= f_pattern(mode_i, '0, '1);
        r_tlast     <= (pkt_len_i == LEN_W'(1));
      end else begin
        if (r_busy && abort_i) r_abort <= 1'b1;
        // tdata/tlast always present the next word, so they stay stable while tready is low.
        if (w_hs) begin
          r_seq      <= w_seq_next;
          r_prbs     <= w_prbs_next;
          r_word_cnt <= w_cnt_next;
          r_tdata    <= f_pattern(r_mode, w_seq_next, w_prbs_next);
          r_tlast    <= (w_cnt_next == r_len - LEN_W'(1));
          if (w_last_hs) r_pkts_sent <= r_pkts_sent + LEN_W'(1);
        end
      end
    end
  end

  assign S_AXIS_tvalid = r_tvalid;
  assign S_AXIS_tdata  = r_tdata;
  assign S_AXIS_tkeep  = '1;
  assign S_AXIS_tlast  = r_tlast;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign pkts_sent_o   = r_pkts_sent;

endmodule

// File: doc/axis_pattern_gen.md
# axis_pattern_gen

Parametrised AXI4-Stream test-pattern source feeding the PS DMA S2MM channel (S_AXIS) from the PL fabric. It generates software-triggered bursts of N packets of L words, with a selectable data pattern and a programmable inter-packet gap. The trigger, length, count and mode come from AXI GPIO outputs. It replaces the fixed single-mode stream generator, and the DMA test software checks its output against a known expected sequence.

## Interface
Parameters:
- DATA_W, 32: tdata width; multiple of 32, range 32..256.
- LEN_W, 16: width of the packet-length and packet-count fields.
- GAP_CYCLES, 4: idle cycles between packets, with tvalid low; 0 allowed.

Ports:
- clk  in  1  stream clock (FCLK_CLK1 domain).
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start_i  in  1  GPIO trigger level; a rising edge starts a run.
- abort_i  in  1  request to end the run early at the next packet boundary.
- mode_i  in  2  pattern select: 0 incrementing, 1 walking-one, 2 PRBS, 3 inverted incrementing.
- pkt_len_i  in  LEN_W  words per packet.
- pkt_num_i  in  LEN_W  packets per run.
- S_AXIS_tready  in  1  DMA ready.
- S_AXIS_tvalid  out  1  data valid.
- S_AXIS_tdata  out  DATA_W  payload.
- S_AXIS_tkeep  out  DATA_W/8  byte enables; constant all-ones.
- S_AXIS_tlast  out  1  last word of a packet.
- busy_o  out  1  high from SEND entry until DONE exit.
- done_o  out  1  one-cycle pulse when a run completes.
- err_o  out  1  one-cycle pulse when a start is rejected.
- pkts_sent_o  out  LEN_W  packets completed in the current or last run.

## Operation
- Edge detect: start_d is a register on start_i, reset 0. An accepted start requires start_i=1, start_d=0, and state IDLE. Edges seen in any other state are ignored.
- States: IDLE, SEND, GAP, DONE.
  - IDLE -> SEND on an accepted start when pkt_len_i≠0 and pkt_num_i≠0.
  - If either field is 0, err_o pulses and the state stays IDLE.
- On an accepted start:
  - Latch mode, pkt_len and pkt_num.
  - Clear seq, word_cnt and pkts_sent.
  - Load the PRBS register with all-ones.
- SEND:
  - tvalid=1. Each handshake (tvalid&tready) advances seq and the PRBS, and increments word_cnt.
  - tlast=1 when word_cnt==pkt_len-1.
  - A handshake with tlast set clears word_cnt and increments pkts_sent. The next state is:
    - DONE if pkts_sent+1==pkt_num or abort is latched;
    - otherwise GAP if GAP_CYCLES>0;
    - otherwise SEND (back-to-back packets).
- GAP: tvalid=0 for exactly GAP_CYCLES cycles, then SEND. If abort is latched on entry or during GAP, go to DONE at the end of the current cycle.
- DONE: done_o=1 for one cycle, then IDLE. busy_o falls when IDLE is entered.
- Abort: abort_i is sampled every cycle while busy and held in a sticky flag, cleared on an accepted start. Abort never truncates a packet: the current packet always ends with tlast at its full length.
- Patterns use seq, a DATA_W-bit counter that wraps modulo 2^DATA_W and continues across packet boundaries within a run:
  - mode 0: tdata=seq.
  - mode 1: tdata=1<<(seq mod DATA_W).
  - mode 2: 32-bit Galois LFSR, polynomial 0x80200003, shifted right with feedback. The value is replicated across DATA_W/32 lanes.
  - mode 3: tdata=~seq.
- pkts_sent_o holds its value after DONE until the next accepted start.

## Timing
- Reset values: tvalid 0, tlast 0, tdata 0, busy 0, done 0, err 0, pkts_sent 0, state IDLE, start_d 0, abort flag 0. tkeep is all-ones, including during reset.
- Start latency: start_i first seen high at edge N, with start_d=0, gives tvalid=1 and the first word on tdata after edge N+1. busy_o rises in the same cycle.
- All stream outputs are registered.
- Handshake rules while tvalid=1:
  - tdata and tlast are held stable until a handshake.
  - tvalid never drops without a handshake.
  - tready may toggle arbitrarily, with full throughput while tready=1.
- Gap timing: tlast handshake at edge M. With GAP_CYCLES=G>0, the next tvalid=1 appears after edge M+G+1. With G=0 there is no bubble.
- The final tlast handshake at edge M gives done_o=1 after edge M+1.
- rst_n low during any state returns all outputs to reset values at the next edge. The partial packet is dropped; the DMA must be reset by software.
- Inputs other than start_i and abort_i are read only in IDLE. Changing them mid-run has no effect.

## Test plan
- mode 0, DATA_W=32, len=4, num=2, G=4, tready=1 -> words 0,1,2,3 (tlast on 3), 4 idle cycles, words 4,5,6,7 (tlast on 7); done_o 1 cycle later; pkts_sent_o=2.
- mode 2, len=3, num=1, tready toggling 1/0 -> 0xFFFFFFFF, then two successive LFSR values; tdata is stable and tvalid held through every tready=0 cycle.
- mode 1, DATA_W=64, len=70 -> the bit position wraps from 63 back to 0 at word 64; lanes are correct.
- abort_i pulse at word 2 of packet 1 of 5, len=8 -> packet 1 completes 8 words with tlast, then DONE; pkts_sent_o=1.
- start with pkt_len_i=0 -> err_o pulses once, no tvalid, busy_o stays 0. Start held high across a full run -> no retrigger.
- rst_n low mid-packet -> every output is at its reset value on the next cycle; a new start then begins again from seq=0.
